// File: rtl/dac_cfg_pkg.sv
// rtl/dac_cfg_pkg.sv - DAC command constants, word field positions, sequencer states and word builder
package dac_cfg_pkg;

    localparam logic [3:0]  CMD_WR_UPD = 4'h3;
    localparam logic [3:0]  CMD_RESET  = 4'h7;
    localparam logic [3:0]  CMD_REF    = 4'h8;

    localparam int          CMD_LSB    = 24;
    localparam int          ADDR_LSB   = 20;
    localparam int          CODE_LSB   = 4;

    localparam logic [15:0] REF_CODE   = 16'h0001;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP,
        ST_FIN
    } state_e;

    function automatic logic [31:0] mk_word(input logic [3:0]  cmd,
                                            input logic [3:0]  addr,
                                            input logic [15:0] code);
        logic [31:0] w;
        w                  = '0;
        w[CMD_LSB  +: 4]   = cmd;
        w[ADDR_LSB +: 4]   = addr;
        w[CODE_LSB +: 16]  = code;
        return w;
    endfunction

endpackage

// File: rtl/dac_cfg_sequencer_if.sv
// rtl/dac_cfg_sequencer_if.sv - word stream between the sequencer and the SPI master
interface dac_cfg_sequencer_if;

    logic [31:0] sdo_data_o;
    logic        sdo_valid_o;
    logic        sdo_ready_i;

    modport master (output sdo_data_o, output sdo_valid_o, input  sdo_ready_i);
    modport slave  (input  sdo_data_o, input  sdo_valid_o, output sdo_ready_i);

endinterface

// File: rtl/dac_cfg_table.sv
// rtl/dac_cfg_table.sv - per-channel DAC code table, one write port, one combinational read port
module dac_cfg_table
    import dac_cfg_pkg::*;
#(
    parameter int          NUM_CH       = 8,
    parameter logic [15:0] DEFAULT_CODE = 16'h8000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we_i,
    input  logic [3:0]  wr_addr_i,
    input  logic [15:0] wr_data_i,
    input  logic [3:0]  rd_addr_i,
    output logic [15:0] rd_data_o
);

    logic [15:0] mem_q [NUM_CH];

    // Addresses at or beyond NUM_CH match no entry, so such writes fall away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mem_q[i] <= DEFAULT_CODE;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (we_i && (wr_addr_i == 4'(i))) begin
                    mem_q[i] <= wr_data_i;
                end
            end
        end
    end

    always_comb begin
        rd_data_o = DEFAULT_CODE;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_addr_i == 4'(i)) begin
                rd_data_o = mem_q[i];
            end
        end
    end

endmodule

// File: rtl/dac_cfg_sequencer.sv
// rtl/dac_cfg_sequencer.sv - DAC init-sequence / raw-word sequencer feeding the SPI master
// Optional: DAC_CFG_AUTO_START_EN runs one full sequence right after reset release.
module dac_cfg_sequencer
    import dac_cfg_pkg::*;
#(
    parameter int          NUM_CH         = 8,
    parameter int          GAP_CYCLES     = 4,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] DEFAULT_CODE   = 16'h8000
) (
    input  logic                       dac_clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    input  logic                       single_valid_i,
    input  logic [31:0]                single_data_i,
    output logic                       single_ready_o,
    input  logic                       tbl_we_i,
    input  logic [3:0]                 tbl_addr_i,
    input  logic [15:0]                tbl_data_i,
    dac_cfg_sequencer_if.master        sdo
);

    localparam int IDX_W = $clog2(NUM_CH + 2);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH + 1);

    state_e             state_q, state_d;
    state_e             after_word;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               seq_q, seq_d;
    logic [31:0]        data_q, data_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
    logic               start_req;
    logic [3:0]         ch_addr;
    logic [15:0]        tbl_code;

`ifdef DAC_CFG_AUTO_START_EN
    logic auto_q;

    always_ff @(posedge dac_clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_q <= 1'b1;
        end else begin
            auto_q <= 1'b0;
        end
    end

    assign start_req = start_i | auto_q;
`else
    assign start_req = start_i;
`endif

    // Word indices 0 and 1 are the reset/reference words; channels start at 2.
    assign ch_addr = 4'(idx_q - IDX_W'(2));

    dac_cfg_table #(
        .NUM_CH       (NUM_CH),
        .DEFAULT_CODE (DEFAULT_CODE)
    ) u_table (
        .clk       (dac_clk),
        .rst_n     (rst_n),
        .we_i      (tbl_we_i),
        .wr_addr_i (tbl_addr_i),
        .wr_data_i (tbl_data_i),
        .rd_addr_i (ch_addr),
        .rd_data_o (tbl_code)
    );

    always_ff @(posedge dac_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            seq_q   <= 1'b0;
            data_q  <= '0;
            gap_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            seq_q   <= seq_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        data_d  = data_q;
        gap_d   = gap_q;
        tmo_d   = tmo_q;
        err_d   = err_q;

        if (!seq_q) begin
            after_word = ST_IDLE;
        end else if (idx_q < LAST_IDX) begin
            after_word = ST_LOAD;
        end else begin
            after_word = ST_FIN;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_req) begin
                    state_d = ST_LOAD;
                    idx_d   = '0;
                    seq_d   = 1'b1;
                    err_d   = 1'b0;
                end else if (single_valid_i) begin
                    state_d = ST_SEND;
                    seq_d   = 1'b0;
                    data_d  = single_data_i;
                    tmo_d   = '0;
                end
            end
            ST_LOAD: begin
                if (idx_q == '0) begin
                    data_d = mk_word(CMD_RESET, 4'h0, 16'h0000);
                end else if (idx_q == IDX_W'(1)) begin
                    data_d = mk_word(CMD_REF, 4'h0, REF_CODE);
                end else begin
                    data_d = mk_word(CMD_WR_UPD, ch_addr, tbl_code);
                end
                state_d = ST_SEND;
                tmo_d   = '0;
            end
            ST_SEND: begin
                if (sdo.sdo_ready_i) begin
                    gap_d = '0;
                    if (GAP_CYCLES == 0) begin
                        state_d = after_word;
                        if (after_word == ST_LOAD) idx_d = idx_q + IDX_W'(1);
                    end else begin
                        state_d = ST_GAP;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    state_d = after_word;
                    if (after_word == ST_LOAD) idx_d = idx_q + IDX_W'(1);
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Valid derives from the async-reset state register, so it drops the instant rst_n falls.
    assign sdo.sdo_valid_o = (state_q == ST_SEND);
    assign sdo.sdo_data_o  = data_q;
    assign single_ready_o  = (state_q == ST_SEND) && !seq_q && sdo.sdo_ready_i;
    assign busy_o          = (state_q != ST_IDLE);
    assign done_o          = (state_q == ST_FIN);
    assign err_o           = err_q;

endmodule

// File: tb/tb_dac_cfg_sequencer.sv
// tb/tb_dac_cfg_sequencer.sv - self-checking bench for dac_cfg_sequencer against a word-list model
module tb_dac_cfg_sequencer;

    localparam logic [31:0] SINGLE_WORD = 32'h0A5A5A50;

    logic        dac_clk;
    logic        rst_n;
    logic        start_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        single_valid_i;
    logic [31:0] single_data_i;
    logic        single_ready_o;
    logic        tbl_we_i;
    logic [3:0]  tbl_addr_i;
    logic [15:0] tbl_data_i;

    dac_cfg_sequencer_if sdo_if();

    dac_cfg_sequencer dut (
        .dac_clk        (dac_clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .single_valid_i (single_valid_i),
        .single_data_i  (single_data_i),
        .single_ready_o (single_ready_o),
        .tbl_we_i       (tbl_we_i),
        .tbl_addr_i     (tbl_addr_i),
        .tbl_data_i     (tbl_data_i),
        .sdo            (sdo_if)
    );

    initial dac_clk = 1'b0;
    always #5 dac_clk = ~dac_clk;

    int          checks;
    int          failures;
    logic [15:0] mtbl [0:7];
    logic [31:0] got_q [$];
    int          busy_cnt, done_cnt, sready_cnt, first_lat, stall_cnt;
    bit          stable_ok, ended, sready_ok;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int i);
        if (i == 0) return 32'h0700_0000;
        if (i == 1) return 32'h0800_0010;
        return (32'h3 << 24) | (32'(i - 2) << 20) | (32'(mtbl[i - 2]) << 4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mtbl[i] = 16'h8000;
    endtask

    task automatic tbl_write(input logic [3:0] a, input logic [15:0] d);
        @(negedge dac_clk);
        tbl_we_i   = 1'b1;
        tbl_addr_i = a;
        tbl_data_i = d;
        if (a < 4'd8) mtbl[a[2:0]] = d;
        @(negedge dac_clk);
        tbl_we_i = 1'b0;
    endtask

    task automatic rand_writes(input int n);
        for (int k = 0; k < n; k++) begin
            tbl_write(4'($urandom_range(0, 15)), 16'($urandom));
        end
    endtask

    task automatic check_seq(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'd10);
        for (int i = 0; i < 10 && i < got_q.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), got_q[i], exp_word(i));
        end
    endtask

    task automatic run(input bit do_start, input bit with_single, input bit rand_ready,
                       input int stall_word, input int stall_len, input bit mid_write,
                       input bit start_again, input int abort_word);
        logic [31:0] held;
        bit seen_busy, wrote, restarted, drop_single;
        got_q.delete();
        busy_cnt = 0; done_cnt = 0; sready_cnt = 0; first_lat = -1; stall_cnt = 0;
        stable_ok = 1'b1; ended = 1'b0; sready_ok = 1'b1;
        seen_busy = 1'b0; wrote = 1'b0; restarted = 1'b0; drop_single = 1'b0; held = '0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge dac_clk);
            start_i  = (cyc == 0) && do_start;
            tbl_we_i = 1'b0;
            if (drop_single) single_valid_i = 1'b0;
            if (cyc == 0 && with_single) begin
                single_valid_i = 1'b1;
                single_data_i  = SINGLE_WORD;
            end
            if (start_again && !restarted && got_q.size() == 3) begin
                start_i   = 1'b1;
                restarted = 1'b1;
            end
            if (mid_write && !wrote && sdo_if.sdo_valid_o && got_q.size() == 4) begin
                tbl_we_i   = 1'b1;
                tbl_addr_i = 4'd7;
                tbl_data_i = 16'hFFFF;
                mtbl[7]    = 16'hFFFF;
                wrote      = 1'b1;
            end
            if (abort_word >= 0 && sdo_if.sdo_valid_o && got_q.size() == abort_word) begin
                rst_n = 1'b0;
                #1;
                check("abort_valid", {31'b0, sdo_if.sdo_valid_o}, 32'd0);
                check("abort_busy", {31'b0, busy_o}, 32'd0);
                ended = 1'b1;
                break;
            end
            sdo_if.sdo_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (sdo_if.sdo_valid_o && got_q.size() == stall_word && stall_cnt < stall_len) begin
                sdo_if.sdo_ready_i = 1'b0;
                if (stall_cnt == 0) held = sdo_if.sdo_data_o;
                else if (sdo_if.sdo_data_o !== held) stable_ok = 1'b0;
                stall_cnt++;
            end
            #1;
            if (busy_o) begin
                busy_cnt++;
                seen_busy = 1'b1;
            end
            if (done_o) done_cnt++;
            if (sdo_if.sdo_valid_o && first_lat < 0) first_lat = cyc;
            if (single_ready_o) begin
                sready_cnt++;
                if (!(sdo_if.sdo_valid_o && sdo_if.sdo_ready_i && sdo_if.sdo_data_o == SINGLE_WORD))
                    sready_ok = 1'b0;
                drop_single = 1'b1;
            end
            if (sdo_if.sdo_valid_o && sdo_if.sdo_ready_i) got_q.push_back(sdo_if.sdo_data_o);
            if (seen_busy && !busy_o && !single_valid_i) begin
                ended = 1'b1;
                break;
            end
        end
        check("run_ended", {31'b0, ended}, 32'd1);
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; start_i = 1'b0; single_valid_i = 1'b0; single_data_i = '0;
        tbl_we_i = 1'b0; tbl_addr_i = '0; tbl_data_i = '0; sdo_if.sdo_ready_i = 1'b1;
        model_reset();

        repeat (3) @(negedge dac_clk);
        check("rst_busy",   {31'b0, busy_o}, 32'd0);
        check("rst_done",   {31'b0, done_o}, 32'd0);
        check("rst_err",    {31'b0, err_o}, 32'd0);
        check("rst_sready", {31'b0, single_ready_o}, 32'd0);
        check("rst_valid",  {31'b0, sdo_if.sdo_valid_o}, 32'd0);
        check("rst_data",   sdo_if.sdo_data_o, 32'd0);
        rst_n = 1'b1;

`ifdef DAC_CFG_AUTO_START_EN
        run(1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, -1);
        check_seq("auto");
`endif

        // Plain sequence with ready tied high.
        run(1'b1, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, -1);
        check_seq("full");
        check("full_busy_cycles", 32'(busy_cnt), 32'd61);
        check("full_done", 32'(done_cnt), 32'd1);
        check("full_latency", 32'(first_lat), 32'd2);
        check("full_err", {31'b0, err_o}, 32'd0);
        check("full_sready", 32'(sready_cnt), 32'd0);

        // Table writes, random backpressure, 50-cycle stall on word 2, ch7 rewrite mid-run.
        rand_writes(24);
        tbl_write(4'd12, 16'hDEAD);
        tbl_write(4'd3, 16'h1234);
        run(1'b1, 1'b0, 1'b1, 2, 50, 1'b1, 1'b0, -1);
        check_seq("tbl");
        if (got_q.size() == 10) begin
            check("tbl_ch3_word", got_q[5], 32'h0331_2340);
            check("tbl_ch7_word", got_q[9], 32'h037F_FFF0);
        end
        check("stall_stable", {31'b0, stable_ok}, 32'd1);
        check("stall_len", 32'(stall_cnt), 32'd50);
        check("tbl_done", 32'(done_cnt), 32'd1);

        // Ready held low forever on word 2: timeout abort.
        run(1'b1, 1'b0, 1'b0, 2, 100000, 1'b0, 1'b0, -1);
        check("tmo_words", 32'(got_q.size()), 32'd2);
        check("tmo_wait", 32'(stall_cnt), 32'd1024);
        check("tmo_err", {31'b0, err_o}, 32'd1);
        check("tmo_done", 32'(done_cnt), 32'd0);
        check("tmo_valid", {31'b0, sdo_if.sdo_valid_o}, 32'd0);

        for (int r = 0; r < 3; r++) begin
            rand_writes(6);
            run(1'b1, 1'b0, 1'b1, -1, 0, 1'b0, 1'b0, -1);
            check_seq($sformatf("rand%0d", r));
            check($sformatf("rand%0d_err", r), {31'b0, err_o}, 32'd0);
            check($sformatf("rand%0d_done", r), 32'(done_cnt), 32'd1);
        end

        // Start and single together, plus an ignored start mid-run.
        run(1'b1, 1'b1, 1'b1, -1, 0, 1'b0, 1'b1, -1);
        check("mix_count", 32'(got_q.size()), 32'd11);
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            check($sformatf("mix_word%0d", i), got_q[i], exp_word(i));
        if (got_q.size() == 11) check("mix_single_word", got_q[10], SINGLE_WORD);
        check("mix_sready_cnt", 32'(sready_cnt), 32'd1);
        check("mix_sready_coincident", {31'b0, sready_ok}, 32'd1);
        check("mix_done", 32'(done_cnt), 32'd1);

        // Reset during word 5 SEND, then a fresh run must see default codes.
        rand_writes(8);
        run(1'b1, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, 5);
        model_reset();
        repeat (2) @(negedge dac_clk);
        rst_n = 1'b1;
`ifdef DAC_CFG_AUTO_START_EN
        run(1'b0, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, -1);
`else
        run(1'b1, 1'b0, 1'b0, -1, 0, 1'b0, 1'b0, -1);
`endif
        check_seq("post_rst");
        check("post_rst_done", 32'(done_cnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
